// File: rtl/id_regfile_stage.sv
// rtl/id_regfile_stage.sv - MIPS decode stage: register file, immediate extender and ID/EX register
module id_regfile_stage #(
    parameter int len            = 32,
    parameter int NB             = 5,
    parameter int NB_sign_extend = 16,
    parameter int ZERO_REG       = 1
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic                      i_valid,
    input  logic [NB-1:0]             i_read1,
    input  logic [NB-1:0]             i_read2,
    input  logic                      i_write_en,
    input  logic [NB-1:0]             i_write,
    input  logic [len-1:0]            i_write_data,
    input  logic [NB_sign_extend-1:0] i_sign_extend,
    input  logic [1:0]                i_ext_mode,
    input  logic                      i_stall,
    input  logic                      i_flush,
    input  logic [NB-1:0]             i_debug_addr,
    output logic [len-1:0]            o_read_data1,
    output logic [len-1:0]            o_read_data2,
    output logic [len-1:0]            o_sign_extend,
    output logic                      o_valid,
    output logic [len-1:0]            o_debug_data
);

    localparam int DEPTH = 1 << NB;
    localparam int PAD   = len - NB_sign_extend;
    localparam bit ZR    = (ZERO_REG != 0);

    logic [len-1:0] regs [DEPTH];
    logic           wr_ok;
    logic [len-1:0] rd1;
    logic [len-1:0] rd2;
    logic [len-1:0] rdd;
    logic [len-1:0] ext;

    // A write to the hardwired zero register is dropped entirely, including from the bypass.
    assign wr_ok = i_write_en && !(ZR && (i_write == '0));

    // Write-through bypass: a read of the address being written sees the incoming data.
    assign rd1 = (ZR && i_read1 == '0) ? '0 :
                 (wr_ok && i_write == i_read1) ? i_write_data : regs[i_read1];
    assign rd2 = (ZR && i_read2 == '0) ? '0 :
                 (wr_ok && i_write == i_read2) ? i_write_data : regs[i_read2];
    assign rdd = (ZR && i_debug_addr == '0) ? '0 :
                 (wr_ok && i_write == i_debug_addr) ? i_write_data : regs[i_debug_addr];

    // Register array; write-back ignores stall and flush so it always completes.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_ok) begin
            regs[i_write] <= i_write_data;
        end
    end

    // Immediate extender: sign by default (mode 11 behaves as 00), zero, or upper placement.
    always_comb begin
        ext = {{PAD{i_sign_extend[NB_sign_extend-1]}}, i_sign_extend};
        case (i_ext_mode)
            2'b01:   ext = {{PAD{1'b0}}, i_sign_extend};
            2'b10:   ext = {i_sign_extend, {PAD{1'b0}}};
            default: ext = {{PAD{i_sign_extend[NB_sign_extend-1]}}, i_sign_extend};
        endcase
    end

    // ID/EX register: flush inserts a bubble, otherwise stall holds, otherwise load.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_read_data1  <= '0;
            o_read_data2  <= '0;
            o_sign_extend <= '0;
            o_valid       <= 1'b0;
        end else if (i_flush) begin
            o_read_data1  <= '0;
            o_read_data2  <= '0;
            o_sign_extend <= '0;
            o_valid       <= 1'b0;
        end else if (!i_stall) begin
            o_read_data1  <= rd1;
            o_read_data2  <= rd2;
            o_sign_extend <= ext;
            o_valid       <= i_valid;
        end
    end

    // Debug read register refreshes every cycle regardless of pipeline control.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_debug_data <= '0;
        end else begin
            o_debug_data <= rdd;
        end
    end

endmodule

// File: tb/tb_id_regfile_stage.sv
// tb/tb_id_regfile_stage.sv - scoreboard bench for id_regfile_stage with both zero-register settings
module tb_id_regfile_stage;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic        i_valid;
    logic [4:0]  i_read1, i_read2, i_write, i_debug_addr;
    logic        i_write_en;
    logic [31:0] i_write_data;
    logic [15:0] i_sign_extend;
    logic [1:0]  i_ext_mode;
    logic        i_stall, i_flush;

    logic [31:0] a_rd1, a_rd2, a_imm, a_dbg;
    logic        a_v;
    logic [31:0] b_rd1, b_rd2, b_imm, b_dbg;
    logic        b_v;

    always #5 i_clk = ~i_clk;

    id_regfile_stage #(.len(32), .NB(5), .NB_sign_extend(16), .ZERO_REG(1)) dut_z (
        .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid),
        .i_read1(i_read1), .i_read2(i_read2),
        .i_write_en(i_write_en), .i_write(i_write), .i_write_data(i_write_data),
        .i_sign_extend(i_sign_extend), .i_ext_mode(i_ext_mode),
        .i_stall(i_stall), .i_flush(i_flush), .i_debug_addr(i_debug_addr),
        .o_read_data1(a_rd1), .o_read_data2(a_rd2), .o_sign_extend(a_imm),
        .o_valid(a_v), .o_debug_data(a_dbg)
    );

    id_regfile_stage #(.len(32), .NB(5), .NB_sign_extend(16), .ZERO_REG(0)) dut_n (
        .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid),
        .i_read1(i_read1), .i_read2(i_read2),
        .i_write_en(i_write_en), .i_write(i_write), .i_write_data(i_write_data),
        .i_sign_extend(i_sign_extend), .i_ext_mode(i_ext_mode),
        .i_stall(i_stall), .i_flush(i_flush), .i_debug_addr(i_debug_addr),
        .o_read_data1(b_rd1), .o_read_data2(b_rd2), .o_sign_extend(b_imm),
        .o_valid(b_v), .o_debug_data(b_dbg)
    );

    typedef struct {
        logic [31:0] a1, a2, imm, adbg;
        logic        v;
        logic [31:0] b1, b2, bdbg;
    } exp_t;

    exp_t        sb[$];
    exp_t        cur;
    logic [31:0] m_z [32];
    logic [31:0] m_n [32];
    int          checks = 0;
    int          errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) begin
            m_z[i] = '0;
            m_n[i] = '0;
        end
        cur = '{default: '0};
    endtask

    // Drives one instruction at the falling edge and records what the outputs must show after the next rising edge.
    task automatic step(input logic v, input logic [4:0] r1, input logic [4:0] r2,
                        input logic we, input logic [4:0] wa, input logic [31:0] wd,
                        input logic [15:0] imm, input logic [1:0] mode,
                        input logic st, input logic fl, input logic [4:0] da);
        logic [31:0] e;
        @(negedge i_clk);
        i_rst = 1'b0;
        i_valid = v; i_read1 = r1; i_read2 = r2;
        i_write_en = we; i_write = wa; i_write_data = wd;
        i_sign_extend = imm; i_ext_mode = mode;
        i_stall = st; i_flush = fl; i_debug_addr = da;
        // Reads in the writing cycle see the new value, so apply the write before reading.
        if (we) begin
            if (wa != 5'd0) m_z[wa] = wd;
            m_n[wa] = wd;
        end
        case (mode)
            2'd1:    e = {16'h0000, imm};
            2'd2:    e = {imm, 16'h0000};
            default: e = 32'($signed(imm));
        endcase
        if (fl) begin
            cur.a1 = '0; cur.a2 = '0; cur.imm = '0; cur.v = 1'b0;
            cur.b1 = '0; cur.b2 = '0;
        end else if (!st) begin
            cur.a1 = m_z[r1]; cur.a2 = m_z[r2];
            cur.b1 = m_n[r1]; cur.b2 = m_n[r2];
            cur.imm = e; cur.v = v;
        end
        cur.adbg = m_z[da];
        cur.bdbg = m_n[da];
        sb.push_back(cur);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic drain();
        for (int k = 0; k < 5 && sb.size() > 0; k++) @(posedge i_clk);
        #3;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic check_zero_outputs(input string tag);
        chk({tag, "_a_rd1"}, a_rd1, 0); chk({tag, "_a_rd2"}, a_rd2, 0);
        chk({tag, "_a_imm"}, a_imm, 0); chk({tag, "_a_v"}, {31'd0, a_v}, 0);
        chk({tag, "_a_dbg"}, a_dbg, 0);
        chk({tag, "_b_rd1"}, b_rd1, 0); chk({tag, "_b_rd2"}, b_rd2, 0);
        chk({tag, "_b_imm"}, b_imm, 0); chk({tag, "_b_v"}, {31'd0, b_v}, 0);
        chk({tag, "_b_dbg"}, b_dbg, 0);
    endtask

    // Monitor: just after each rising edge compare the outputs with the oldest expectation.
    always begin
        exp_t e;
        @(posedge i_clk);
        #2;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("rd1_z", a_rd1, e.a1);
            chk("rd2_z", a_rd2, e.a2);
            chk("imm_z", a_imm, e.imm);
            chk("valid_z", {31'd0, a_v}, {31'd0, e.v});
            chk("dbg_z", a_dbg, e.adbg);
            chk("rd1_n", b_rd1, e.b1);
            chk("rd2_n", b_rd2, e.b2);
            chk("imm_n", b_imm, e.imm);
            chk("valid_n", {31'd0, b_v}, {31'd0, e.v});
            chk("dbg_n", b_dbg, e.bdbg);
        end
    end

    initial begin
        i_rst = 1'b1; i_valid = 0; i_read1 = 0; i_read2 = 0;
        i_write_en = 0; i_write = 0; i_write_data = 0;
        i_sign_extend = 0; i_ext_mode = 0; i_stall = 0; i_flush = 0; i_debug_addr = 0;
        model_reset();
        #12;
        check_zero_outputs("reset");

        // Preload r5, then reset asynchronously mid-cycle.
        step(1, 5, 5, 1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 5);
        step(1, 5, 0, 0, 0, 0, 0, 0, 0, 0, 5);
        drain();
        chk("pre_reset_r5", a_rd1, 32'hDEADBEEF);
        i_rst = 1'b1;
        #1;
        check_zero_outputs("async_reset");
        model_reset();
        step(1, 5, 5, 0, 0, 0, 0, 0, 0, 0, 5);

        // Write with same-cycle bypass, then from the array.
        step(1, 7, 0, 1, 7, 32'h12345678, 0, 0, 0, 0, 7);
        idle(1);
        step(1, 7, 7, 0, 0, 0, 0, 0, 0, 0, 7);

        // Zero register write, through the bypass and later.
        step(1, 0, 0, 1, 0, 32'hFFFFFFFF, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Extender modes on 0x8001.
        for (int m = 0; m < 4; m++) step(1, 0, 0, 0, 0, 0, 16'h8001, 2'(m), 0, 0, 0);

        // Stall holds, write during stall lands, flush beats stall.
        step(1, 1, 0, 1, 1, 32'h11, 16'h0042, 0, 0, 0, 1);
        step(1, 2, 3, 1, 2, 32'h22, 16'h1234, 1, 1, 0, 2);
        step(1, 4, 5, 0, 0, 0, 16'h5555, 2, 1, 0, 1);
        step(0, 6, 6, 0, 0, 0, 16'hFFFF, 0, 1, 0, 2);
        step(1, 2, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        step(1, 3, 3, 0, 0, 0, 16'h7777, 0, 1, 1, 2);
        step(1, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0);

        // Debug port during stall.
        step(1, 0, 0, 1, 31, 32'hA5A5A5A5, 0, 0, 1, 0, 31);
        step(1, 31, 0, 0, 0, 0, 0, 0, 0, 0, 31);

        // Randomized traffic over a small address window to hit the bypass often.
        for (int n = 0; n < 400; n++) begin
            logic [4:0] r1, r2, wa, da;
            r1 = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
            r2 = 5'($urandom_range(0, 7));
            wa = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
            da = 5'($urandom_range(0, 7));
            step(1'($urandom_range(0, 1)), r1, r2, $urandom_range(0, 9) < 7, wa, $urandom,
                 16'($urandom), 2'($urandom_range(0, 3)),
                 $urandom_range(0, 99) < 15, $urandom_range(0, 99) < 8, da);
        end

        drain();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
